kbd_scancode_queue: RTL and testbench
=====================================

// Module: kbd_scancode_queue
// PURPOSE
//  Consumes raw PS/2 set-2 bytes from Keyboard_dev (Keyboard_Data + ready_pulse).
//  Folds E0/F0 prefixes into one {ext,brk,code} key event and buffers events in a FIFO.
//  The CPU-side keyboard MMIO port reads events from the FIFO.
//  The FIFO is first-word-fall-through: the head event is always presented.
// PARAMETERS
//  AW              4        FIFO address width; depth = 2**AW entries (16)
//  PREFIX_TIMEOUT  1000000  clk cycles a pending prefix survives without a new byte
// PORTS
//  clk            in   1     system clock, rising edge
//  reset          in   1     asynchronous, active-low reset (0 = reset)
//  Keyboard_Data  in   8     received PS/2 byte, valid when ready_pulse=1
//  ready_pulse    in   1     one-cycle strobe per received byte
//  rd_en          in   1     pop head event (one pop per high cycle)
//  clr_ovf        in   1     clear sticky overflow
//  key_valid      out  1     FIFO not empty
//  key_code       out  8     head event scancode (0 when empty)
//  key_ext        out  1     head event had E0 prefix (0 when empty)
//  key_brk        out  1     head event is break/release (0 when empty)
//  count          out  AW+1  number of queued events, 0..2**AW
//  overflow       out  1     sticky: an event was dropped because FIFO was full
//  kbd_err        out  1     sticky: keyboard error byte 0x00 or 0xFF received
// BEHAVIOUR
//  Reset (async, reset=0):
//   - FSM -> IDLE; FIFO pointers and count cleared; timeout counter cleared.
//   - overflow, kbd_err, key_valid = 0; key_code, key_ext, key_brk = 0.
//   - A reset in the middle of a prefix sequence discards that sequence.
//  A byte b is accepted only in a cycle with ready_pulse=1.
//  Prefix FSM:
//   IDLE:
//    - E0 -> S_E0; F0 -> S_F0.
//    - 00/FF -> set kbd_err, nothing queued.
//    - any other byte -> push {0,0,b}.
//   S_E0:
//    - F0 -> S_E0F0; E0 -> stay.
//    - any other byte -> push {1,0,b}, -> IDLE.
//   S_F0:
//    - F0 -> stay; E0 -> S_E0 (stale F0 dropped).
//    - any other byte -> push {0,1,b}, -> IDLE.
//   S_E0F0:
//    - E0/F0 -> IDLE, sequence discarded.
//    - any other byte -> push {1,1,b}, -> IDLE.
//   00/FF received in any non-IDLE state -> set kbd_err, -> IDLE.
//   E1 (Pause) has no special handling; it is queued as a normal make byte.
//  Timeout:
//   - Counter clears on every accepted byte.
//   - Counts while FSM != IDLE.
//   - Reaching PREFIX_TIMEOUT -> FSM to IDLE, pending prefix dropped.
//  Latency: push from a byte at edge N gives key_valid/count updated after edge N+1.
//  FIFO push/pop rules:
//   - Pop with rd_en=1 and count=0: ignored.
//   - Push + pop in the same cycle with 0<count<full: both occur, count unchanged.
//   - Push + pop with count=0: push occurs, pop ignored, count -> 1.
//   - Push + pop with count=full: both occur, count stays full, no overflow.
//   - Push alone when full: event dropped, overflow set, stored data untouched.
//   - Pointers wrap modulo 2**AW; count is AW+1 bits wide so it can reach full.
//  Sticky flags:
//   - clr_ovf clears overflow; a set in the same cycle wins.
//   - kbd_err clears only on reset.
// TESTING
//  1. Byte 1C -> after 1 cycle: key_valid=1, code=1C, ext=0, brk=0, count=1.
//     Then rd_en -> key_valid=0, count=0.
//  2. F0 alone -> count=0. F0 1C -> one event: code=1C, brk=1, ext=0.
//  3. E0 75, then E0 F0 75 -> two events: {1,0,75} then {1,1,75}, popped in order.
//  4. 17 makes 01..11 with no rd_en -> count=16, overflow=1, head=01.
//     Pop all 16 -> codes 01..10; clr_ovf -> overflow=0.
//  5. Full FIFO, push 22 with rd_en in the same cycle -> count=16, overflow=0, 22 is the tail.
//     rd_en on an empty FIFO -> no change.
//  6. E0, idle PREFIX_TIMEOUT cycles, then 1C -> event {0,0,1C}.
//     Byte FF -> kbd_err=1, nothing queued.
//  7. 3 events queued, then F0, then reset=0 mid-stream -> count=0, all outputs 0.
//     After release, 1C -> make {0,0,1C}.

Source files
------------

// File: rtl/kbd_scancode_queue.sv
// rtl/kbd_scancode_queue.sv - PS/2 set-2 prefix folder feeding a first-word-fall-through key event FIFO
module kbd_scancode_queue #(
    parameter int AW             = 4,
    parameter int PREFIX_TIMEOUT = 1000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    Keyboard_Data,
    input  logic          ready_pulse,
    input  logic          rd_en,
    input  logic          clr_ovf,
    output logic          key_valid,
    output logic [7:0]    key_code,
    output logic          key_ext,
    output logic          key_brk,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          kbd_err
);

    localparam int DEPTH = 1 << AW;
    localparam int TW    = $clog2(PREFIX_TIMEOUT + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, S_E0, S_F0, S_E0F0} state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   tmo_cnt;
    logic            timed_out;
    logic            is_e0, is_f0, is_bad;
    logic            push_nx, err_set;
    logic [9:0]      ev_nx;
    logic            ev_push;
    logic [9:0]      ev_data;

    logic [9:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            empty, full, do_pop, do_push, drop;

    assign is_e0     = (Keyboard_Data == 8'hE0);
    assign is_f0     = (Keyboard_Data == 8'hF0);
    assign is_bad    = (Keyboard_Data == 8'h00) || (Keyboard_Data == 8'hFF);
    assign timed_out = (state != IDLE) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (ready_pulse) begin
            if (is_bad) begin
                state_nx = IDLE;
            end else begin
                case (state)
                    IDLE:    if (is_e0) state_nx = S_E0; else if (is_f0) state_nx = S_F0;
                    S_E0:    if (is_f0) state_nx = S_E0F0; else if (!is_e0) state_nx = IDLE;
                    S_F0:    if (is_e0) state_nx = S_E0; else if (!is_f0) state_nx = IDLE;
                    default: state_nx = IDLE;
                endcase
            end
        end else if (timed_out) begin
            state_nx = IDLE;
        end
    end

    // Any non-prefix, non-error byte closes the sequence; the flags come from the prefix state.
    always_comb begin
        push_nx = ready_pulse && !is_bad && !is_e0 && !is_f0;
        err_set = ready_pulse && is_bad;
        ev_nx   = {(state == S_E0) || (state == S_E0F0),
                   (state == S_F0) || (state == S_E0F0),
                   Keyboard_Data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
            ev_push <= 1'b0;
            ev_data <= '0;
            kbd_err <= 1'b0;
        end else begin
            ev_push <= push_nx;
            ev_data <= ev_nx;
            if (err_set) kbd_err <= 1'b1;
            if (ready_pulse || state == IDLE || timed_out) tmo_cnt <= '0;
            else                                          tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = rd_en && !empty;
    assign do_push = ev_push && (!full || do_pop);
    assign drop    = ev_push && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= ev_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    always_comb begin
        key_valid = !empty;
        {key_ext, key_brk, key_code} = empty ? 10'd0 : mem[rd_ptr];
    end

endmodule

// File: tb/tb_kbd_scancode_queue.sv
// tb/tb_kbd_scancode_queue.sv - randomized and directed bench for kbd_scancode_queue against an event-queue model
module tb_kbd_scancode_queue;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  Keyboard_Data = 8'h00;
    logic        ready_pulse = 1'b0;
    logic        rd_en = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        key_ext;
    logic        key_brk;
    logic [AW:0] count;
    logic        overflow;
    logic        kbd_err;

    kbd_scancode_queue #(.AW(AW), .PREFIX_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .Keyboard_Data(Keyboard_Data), .ready_pulse(ready_pulse),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .key_valid(key_valid), .key_code(key_code),
        .key_ext(key_ext), .key_brk(key_brk), .count(count), .overflow(overflow), .kbd_err(kbd_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: queue of {ext,brk,code}, pending-prefix flags, one-cycle staging of a finished event.
    bit [9:0] q[$];
    bit       pend_e0, pend_f0;
    int       idle_cnt;
    bit       stg;
    bit [9:0] stg_d;
    bit       m_ovf, m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        pend_e0 = 0; pend_f0 = 0; idle_cnt = 0;
        stg = 0; stg_d = '0; m_ovf = 0; m_err = 0;
    endtask

    task automatic model_edge(input bit v, input bit [7:0] b, input bit rd, input bit clr);
        bit pop_ok, dropped;
        pop_ok  = rd && (q.size() > 0);
        dropped = 0;
        if (pop_ok) void'(q.pop_front());
        if (stg) begin
            if (q.size() < DEPTH) q.push_back(stg_d);
            else dropped = 1;
        end
        if (dropped) m_ovf = 1;
        else if (clr) m_ovf = 0;
        stg = 0;
        if (v) begin
            idle_cnt = 0;
            if (b == 8'h00 || b == 8'hFF) begin
                m_err = 1; pend_e0 = 0; pend_f0 = 0;
            end else if (b == 8'hE0 || b == 8'hF0) begin
                if (pend_e0 && pend_f0) begin
                    pend_e0 = 0; pend_f0 = 0;
                end else if (b == 8'hE0) begin
                    pend_e0 = 1; pend_f0 = 0;
                end else begin
                    pend_f0 = 1;
                end
            end else begin
                stg = 1; stg_d = {pend_e0, pend_f0, b};
                pend_e0 = 0; pend_f0 = 0;
            end
        end else if (pend_e0 || pend_f0) begin
            idle_cnt++;
            if (idle_cnt == TMO) begin
                pend_e0 = 0; pend_f0 = 0; idle_cnt = 0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        bit [10:0] exp_key;
        exp_key = (q.size() > 0) ? {1'b1, q[0]} : 11'd0;
        check_eq({tag, ".key"}, {key_valid, key_ext, key_brk, key_code}, exp_key);
        check_eq({tag, ".count"}, count, q.size());
        check_eq({tag, ".flags"}, {overflow, kbd_err}, {m_ovf, m_err});
    endtask

    task automatic step(input bit v, input bit [7:0] b, input bit rd, input bit clr);
        ready_pulse = v; Keyboard_Data = b; rd_en = rd; clr_ovf = clr;
        @(posedge clk);
        model_edge(v, b, rd, clr);
        #1;
        ready_pulse = 0; rd_en = 0; clr_ovf = 0;
        compare_all("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_clear();
        #1;
        check_eq("rst.outs", {key_valid, key_ext, key_brk, key_code, count, overflow, kbd_err}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        compare_all("rst");
    endtask

    initial begin
        model_clear();
        #3;
        apply_reset();

        // 1: plain make, one-cycle latency, pop
        step(1, 8'h1C, 0, 0);
        check_eq("t1.lat", key_valid, 0);
        idle(1);
        check_eq("t1.key", {key_valid, key_ext, key_brk, key_code}, {1'b1, 2'b00, 8'h1C});
        check_eq("t1.cnt", count, 1);
        step(0, 8'h00, 1, 0);
        check_eq("t1.pop", {key_valid, count}, 0);

        // 2: lone F0 queues nothing, F0 1C is a break
        step(1, 8'hF0, 0, 0);
        idle(2);
        check_eq("t2.none", count, 0);
        step(1, 8'h1C, 0, 0);
        idle(1);
        check_eq("t2.brk", {key_valid, key_ext, key_brk, key_code}, {1'b1, 2'b01, 8'h1C});
        step(0, 8'h00, 1, 0);

        // 3: extended make then extended break
        step(1, 8'hE0, 0, 0); step(1, 8'h75, 0, 0);
        step(1, 8'hE0, 0, 0); step(1, 8'hF0, 0, 0); step(1, 8'h75, 0, 0);
        idle(1);
        check_eq("t3.cnt", count, 2);
        check_eq("t3.first", {key_ext, key_brk, key_code}, {2'b10, 8'h75});
        step(0, 8'h00, 1, 0);
        check_eq("t3.second", {key_ext, key_brk, key_code}, {2'b11, 8'h75});
        step(0, 8'h00, 1, 0);

        // 4: overflow on the 17th event, data intact, clr_ovf
        for (int i = 1; i <= 17; i++) step(1, 8'(i), 0, 0);
        idle(1);
        check_eq("t4.cnt", count, 16);
        check_eq("t4.ovf", overflow, 1);
        check_eq("t4.head", key_code, 8'h01);
        for (int i = 1; i <= 16; i++) begin
            check_eq("t4.code", key_code, i);
            step(0, 8'h00, 1, 0);
        end
        step(0, 8'h00, 0, 1);
        check_eq("t4.clr", overflow, 0);

        // 5: push and pop together while full, then pop on empty
        for (int i = 1; i <= 16; i++) step(1, 8'(i), 0, 0);
        idle(1);
        step(1, 8'h22, 0, 0);
        step(0, 8'h00, 1, 0);
        check_eq("t5.cnt", count, 16);
        check_eq("t5.ovf", overflow, 0);
        for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0);
        check_eq("t5.tail", {key_valid, key_code}, {1'b1, 8'h22});
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        check_eq("t5.empty", {key_valid, count, overflow}, 0);

        // 6: prefix survives TMO-1 idle cycles, dies after TMO; error byte
        step(1, 8'hE0, 0, 0);
        idle(TMO - 1);
        step(1, 8'h1C, 0, 0);
        idle(1);
        check_eq("t6.alive", {key_ext, key_brk, key_code}, {2'b10, 8'h1C});
        step(0, 8'h00, 1, 0);
        step(1, 8'hE0, 0, 0);
        idle(TMO + 2);
        step(1, 8'h1C, 0, 0);
        idle(1);
        check_eq("t6.tmo", {key_valid, key_ext, key_brk, key_code}, {1'b1, 2'b00, 8'h1C});
        step(0, 8'h00, 1, 0);
        step(1, 8'hFF, 0, 0);
        idle(1);
        check_eq("t6.err", {kbd_err, count}, {1'b1, 5'd0});

        // 7: reset mid-prefix discards everything
        step(1, 8'h11, 0, 0); step(1, 8'h12, 0, 0); step(1, 8'h13, 0, 0);
        step(1, 8'hF0, 0, 0);
        apply_reset();
        step(1, 8'h1C, 0, 0);
        idle(1);
        check_eq("t7.make", {key_valid, key_ext, key_brk, key_code, kbd_err}, {1'b1, 2'b00, 8'h1C, 1'b0});
        step(0, 8'h00, 1, 0);

        // Randomized traffic with prefix-heavy bytes, long gaps and phase-varying drain rate
        for (int i = 0; i < 5000; i++) begin
            bit       v, rd, clr;
            bit [7:0] b;
            int       r;
            v = ($urandom_range(0, 9) < 4);
            r = $urandom_range(0, 15);
            case (r)
                0, 1:    b = 8'hE0;
                2, 3:    b = 8'hF0;
                4:       b = 8'h00;
                5:       b = 8'hFF;
                default: b = 8'($urandom);
            endcase
            rd  = ((i / 500) % 2 == 1) ? ($urandom_range(0, 9) < 1) : ($urandom_range(0, 9) < 6);
            clr = ($urandom_range(0, 19) == 0);
            step(v, b, rd, clr);
            if ($urandom_range(0, 63) == 0) idle($urandom_range(TMO - 2, TMO + 2));
            if ($urandom_range(0, 999) == 0) apply_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
